// File: rtl/mp_pkg.sv
// Shared types and dimensions for the motion-pipeline frame sequencer and the
// downstream background writer.
package mp_pkg;

    localparam int WIDTH_BITS  = 11;
    localparam int HEIGHT_BITS = 10;
    localparam int ADDR_BITS   = WIDTH_BITS + HEIGHT_BITS;
    localparam int PIXEL_BITS  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } mp_seq_state_t;

endpackage

// File: rtl/mp_raster_counter.sv
// Raster position counters (x, y, linear address) for one frame; shared by the
// sequencer and the background writer.
module mp_raster_counter #(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int ADDR_BITS   = 21
) (
    input  logic                   clk,
    input  logic                   srst_i,
    input  logic                   clr_i,
    input  logic                   inc_i,
    input  logic [WIDTH_BITS-1:0]  width_i,
    input  logic [HEIGHT_BITS-1:0] height_i,
    output logic [ADDR_BITS-1:0]   addr_o,
    output logic                   last_pixel_o
);

    localparam logic [WIDTH_BITS-1:0]  X_ONE = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [HEIGHT_BITS-1:0] Y_ONE = {{(HEIGHT_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0]   A_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [WIDTH_BITS-1:0]  x_q, x_d;
    logic [HEIGHT_BITS-1:0] y_q, y_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   x_last;
    logic                   y_last;

    assign x_last = (x_q == width_i - X_ONE);
    assign y_last = (y_q == height_i - Y_ONE);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (inc_i) begin
            addr_d = addr_q + A_ONE;
            if (x_last) begin
                x_d = '0;
                y_d = y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o       = addr_q;
    assign last_pixel_o = x_last & y_last;

endmodule

// File: rtl/mp_frame_sequencer.sv
// Feeds camera pixels into the motion pipeline, pairing each with its stored
// background pixel and deciding which frames refresh the background.
module mp_frame_sequencer #(
    parameter int WIDTH_BITS  = mp_pkg::WIDTH_BITS,
    parameter int HEIGHT_BITS = mp_pkg::HEIGHT_BITS,
    parameter int ADDR_BITS   = mp_pkg::ADDR_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          capture_bg,
    input  logic [WIDTH_BITS-1:0]         width,
    input  logic [HEIGHT_BITS-1:0]        height,
    input  logic [mp_pkg::PIXEL_BITS-1:0] in_pixel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          mem_rd_en,
    output logic [ADDR_BITS-1:0]          mem_rd_addr,
    input  logic [mp_pkg::PIXEL_BITS-1:0] mem_rd_data,
    output logic                          enable,
    output logic [mp_pkg::PIXEL_BITS-1:0] rbg_pixel,
    output logic [mp_pkg::PIXEL_BITS-1:0] memory_pixel,
    output logic                          wr_background,
    output logic                          last_in_frame,
    output logic                          busy,
    output logic                          frame_done
);

    import mp_pkg::*;

    mp_seq_state_t           state_q, state_d;
    logic [WIDTH_BITS-1:0]   width_q, width_d;
    logic [HEIGHT_BITS-1:0]  height_q, height_d;
    logic                    bg_frame_q, bg_frame_d;
    logic                    bg_valid_q, bg_valid_d;
    logic                    enable_q;
    logic                    frame_done_q;
    logic [PIXEL_BITS-1:0]   rbg_pixel_q, rbg_pixel_d;

    logic                    accept;
    logic                    start_ok;
    logic                    cnt_clr;
    logic                    last_pixel;
    logic [ADDR_BITS-1:0]    addr;

    assign in_ready = (state_q == RUN);
    assign accept   = in_ready & in_valid;
    assign start_ok = start & (width != '0) & (height != '0);

    mp_raster_counter #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_raster (
        .clk          (clk),
        .srst_i       (rst),
        .clr_i        (cnt_clr),
        .inc_i        (accept),
        .width_i      (width_q),
        .height_i     (height_q),
        .addr_o       (addr),
        .last_pixel_o (last_pixel)
    );

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        bg_frame_d  = bg_frame_q;
        bg_valid_d  = bg_valid_q;
        rbg_pixel_d = rbg_pixel_q;
        cnt_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = RUN;
                    width_d    = width;
                    height_d   = height;
                    // No stored background yet means this frame must capture one.
                    bg_frame_d = capture_bg | ~bg_valid_q;
                    cnt_clr    = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    rbg_pixel_d = in_pixel;
                    if (last_pixel) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                if (bg_frame_q) begin
                    bg_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            bg_frame_q   <= 1'b0;
            bg_valid_q   <= 1'b0;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            rbg_pixel_q  <= '0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            bg_frame_q   <= bg_frame_d;
            bg_valid_q   <= bg_valid_d;
            enable_q     <= accept;
            frame_done_q <= (state_q == FLUSH);
            rbg_pixel_q  <= rbg_pixel_d;
        end
    end

    assign mem_rd_en     = accept & ~bg_frame_q;
    assign mem_rd_addr   = mem_rd_en ? addr : '0;
    assign enable        = enable_q;
    assign rbg_pixel     = rbg_pixel_q;
    // Read data arrives one cycle after the strobe, i.e. alongside enable.
    assign memory_pixel  = (enable_q & ~bg_frame_q) ? mem_rd_data : '0;
    assign wr_background = enable_q & bg_frame_q;
    // FLUSH is entered only by accepting the final pixel, so its enable is the last one.
    assign last_in_frame = (state_q == FLUSH);
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_mp_frame_sequencer.sv
// Self-checking bench for mp_frame_sequencer: table of directed frames followed
// by randomized frames, all checked against a frame-level reference model.
module tb_mp_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        capture_bg;
    logic [10:0] width;
    logic [9:0]  height;
    logic [31:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic        mem_rd_en;
    logic [20:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        enable;
    logic [31:0] rbg_pixel;
    logic [31:0] memory_pixel;
    logic        wr_background;
    logic        last_in_frame;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit bg_valid_m = 1'b0;

    always #5 clk = ~clk;

    mp_frame_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .capture_bg    (capture_bg),
        .width         (width),
        .height        (height),
        .in_pixel      (in_pixel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .enable        (enable),
        .rbg_pixel     (rbg_pixel),
        .memory_pixel  (memory_pixel),
        .wr_background (wr_background),
        .last_in_frame (last_in_frame),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // Background memory: content at address a is 0x100+a; garbage when not read.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'h100 + 32'(mem_rd_addr);
        else           mem_rd_data <= $urandom;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic chk_enable(input bit en, input logic [31:0] px, input logic [31:0] mpx,
                              input bit wb, input bit last);
        chk("enable", 64'(enable), 64'(en));
        if (en) begin
            chk("rbg_pixel", 64'(rbg_pixel), 64'(px));
            chk("memory_pixel", 64'(memory_pixel), 64'(mpx));
            chk("wr_background", 64'(wr_background), 64'(wb));
            chk("last_in_frame", 64'(last_in_frame), 64'(last));
        end else begin
            chk("wr_background_idle", 64'(wr_background), 64'd0);
            chk("last_in_frame_idle", 64'(last_in_frame), 64'd0);
        end
    endtask

    task automatic reset_seq();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_last", 64'(last_in_frame), 64'd0);
        chk("rst_wr_bg", 64'(wr_background), 64'd0);
        chk("rst_memory_pixel", 64'(memory_pixel), 64'd0);
        chk("rst_rbg_pixel", 64'(rbg_pixel), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        in_valid = 1'b1; in_pixel = $urandom;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        chk("post_rst_enable", 64'(enable), 64'd0);
        chk("post_rst_frame_done", 64'(frame_done), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        bg_valid_m = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic bad_start(input int w, input int h);
        start = 1'b1; capture_bg = 1'b1; width = 11'(w); height = 10'(h);
        @(negedge clk);
        start = 1'b0;
        chk("badstart_busy", 64'(busy), 64'd0);
        chk("badstart_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_pixel = $urandom;
        @(negedge clk);
        chk("badstart_enable", 64'(enable), 64'd0);
        chk("badstart_busy2", 64'(busy), 64'd0);
        in_valid = 1'b0;
        $display("bad start %0dx%0d: ignored", w, h);
    endtask

    // Runs one frame starting at the current negedge; abort>=0 resets after that many accepts.
    task automatic do_frame(input int w, input int h, input bit cap, input bit exp_bg,
                            input logic [7:0] vpat, input int abort, input bit smid,
                            output int n_en);
        logic [31:0] pix [0:63];
        int n, acc, cyc, pk;
        bit pend;
        n = w * h; acc = 0; cyc = 0; pk = 0; pend = 1'b0; n_en = 0;
        start = 1'b1; capture_bg = cap; width = 11'(w); height = 10'(h); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; capture_bg = ~cap;
        width = 11'($urandom); height = 10'($urandom);
        while (acc < n) begin
            n_en += int'(enable);
            chk_enable(pend, pix[pk], exp_bg ? 32'h0 : 32'h100 + 32'(pk), exp_bg, 1'b0);
            chk("frame_done_run", 64'(frame_done), 64'd0);
            chk("busy_run", 64'(busy), 64'd1);
            if (abort >= 0 && acc == abort) begin
                reset_seq();
                return;
            end
            start = smid && (acc == n / 2);
            if (start) begin
                width = 11'd1; height = 10'd1; capture_bg = 1'b1;
            end
            in_valid = vpat[cyc % 8] || (cyc > 100);
            in_pixel = $urandom;
            #1;
            chk("in_ready", 64'(in_ready), 64'd1);
            chk("mem_rd_en", 64'(mem_rd_en), 64'(in_valid & ~exp_bg));
            if (in_valid && !exp_bg) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(acc));
            pend = in_valid;
            if (in_valid) begin
                pix[acc] = in_pixel; pk = acc; acc++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        n_en += int'(enable);
        chk_enable(1'b1, pix[n-1], exp_bg ? 32'h0 : 32'h100 + 32'(n-1), exp_bg, 1'b1);
        chk("busy_flush", 64'(busy), 64'd1);
        chk("frame_done_flush", 64'(frame_done), 64'd0);
        in_valid = 1'b1; in_pixel = $urandom;
        #1;
        chk("in_ready_flush", 64'(in_ready), 64'd0);
        chk("mem_rd_en_flush", 64'(mem_rd_en), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_en += int'(enable);
        chk("enable_done", 64'(enable), 64'd0);
        chk("frame_done", 64'(frame_done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("last_done", 64'(last_in_frame), 64'd0);
        if (exp_bg) bg_valid_m = 1'b1;
    endtask

    typedef struct {
        int         w;
        int         h;
        bit         cap;
        logic [7:0] vpat;
        int         abort;
        bit         smid;
        int         idle;
        bit         exp_bg;
        int         exp_en;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n_en, n, abort, w, h, idle;
        bit cap, bg;
        logic [7:0] vpat;

        //              w  h cap vpat   abort smid idle bg  enables
        tbl[0] = '{4, 2, 1'b0, 8'hFF, -1, 1'b0, 2, 1'b1, 8};
        tbl[1] = '{4, 2, 1'b0, 8'hFF, -1, 1'b0, 1, 1'b0, 8};
        tbl[2] = '{3, 3, 1'b0, 8'h59, -1, 1'b0, 0, 1'b0, 9};
        tbl[3] = '{4, 4, 1'b0, 8'hFF,  5, 1'b0, 0, 1'b0, 5};
        tbl[4] = '{2, 3, 1'b0, 8'hFF, -1, 1'b1, 1, 1'b1, 6};
        tbl[5] = '{1, 1, 1'b1, 8'hFF, -1, 1'b0, 0, 1'b1, 1};
        tbl[6] = '{5, 1, 1'b0, 8'hFF, -1, 1'b0, 0, 1'b0, 5};
        tbl[7] = '{1, 7, 1'b1, 8'h6D, -1, 1'b0, 2, 1'b1, 7};
        tbl[8] = '{3, 2, 1'b0, 8'hB5, -1, 1'b1, 0, 1'b0, 6};

        rst = 1'b1; start = 1'b1; capture_bg = 1'b0; width = 11'd4; height = 10'd4;
        in_pixel = 32'h0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset_seq();
        bad_start(0, 3);
        bad_start(5, 0);

        for (int i = 0; i < 9; i++) begin
            do_frame(tbl[i].w, tbl[i].h, tbl[i].cap, tbl[i].exp_bg, tbl[i].vpat,
                     tbl[i].abort, tbl[i].smid, n_en);
            chk("enable_count", 64'(n_en), 64'(tbl[i].exp_en));
            $display("vector %0d: %0dx%0d cap=%0d bg=%0d enables=%0d", i, tbl[i].w, tbl[i].h,
                     tbl[i].cap, tbl[i].exp_bg, n_en);
            repeat (tbl[i].idle) @(negedge clk);
        end

        for (int r = 0; r < 25; r++) begin
            w     = $urandom_range(1, 5);
            h     = $urandom_range(1, 4);
            n     = w * h;
            cap   = ($urandom_range(3) == 0);
            bg    = cap | ~bg_valid_m;
            vpat  = 8'($urandom) | 8'h01;
            abort = ($urandom_range(5) == 0) ? int'($urandom_range(n - 1)) : -1;
            idle  = $urandom_range(2);
            do_frame(w, h, cap, bg, vpat, abort, ($urandom_range(3) == 0), n_en);
            chk("rand_enable_count", 64'(n_en), 64'((abort >= 0) ? abort : n));
            $display("random %0d: %0dx%0d cap=%0d bg=%0d abort=%0d enables=%0d", r, w, h,
                     cap, bg, abort, n_en);
            repeat (idle) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
